// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Package : stream_mux_pkg
// Shared constants and helpers for the round-robin stream selector.
// Rev     : 1.0
// ============================================================================
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Interface : stream_mux_rr_if
// Per-channel input handshakes plus the registered output stream.
// Rev       : 1.0
// ============================================================================
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int SEL_W = clog2(N);

    logic             mode_rr;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_ready;

    modport master (
        output mode_rr, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode_rr, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational grant: explicit select, or round-robin starting after `last`.
// Rev    : 1.0
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2(N)
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [SEL_W-1:0] last,
    input  wire logic [SEL_W-1:0] sel,
    input  wire logic             mode_rr,
    output logic      [N-1:0]     grant,
    output logic      [SEL_W-1:0] grant_idx,
    output logic                  any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        if (mode_rr == MODE_RR) begin
            // Offset N wraps back onto `last` itself, so a lone requester there still wins.
            for (int off = 1; off <= N; off++) begin
                if (!any && req[(int'(last) + off) % N]) begin
                    any                          = 1'b1;
                    grant_idx                    = SEL_W'((int'(last) + off) % N);
                    grant[(int'(last) + off) % N] = 1'b1;
                end
            end
        end else begin
            // Out-of-range select values never match any channel, giving no grant.
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i) && req[i]) begin
                    any       = 1'b1;
                    grant_idx = SEL_W'(i);
                    grant[i]  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module : stream_mux_rr
// N-channel W-bit stream selector with one-entry registered output stage.
// Rev    : 1.0
// ============================================================================
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4
) (
    input wire logic       clk,
    input wire logic       rst_n,
    stream_mux_rr_if.slave bus
);

    localparam int SEL_W = clog2(N);

    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_any;
    logic             w_load_en;
    logic             w_xfer;

    logic [SEL_W-1:0] r_last;
    logic             r_out_valid;
    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_ch;

    rr_arbiter #(.N(N)) u_arb (
        .req       (bus.in_valid),
        .last      (r_last),
        .sel       (bus.sel),
        .mode_rr   (bus.mode_rr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_xfer    = w_any && w_load_en && rst_n;

    // Gate with rst_n so no channel sees ready while reset is held.
    assign bus.in_ready  = w_grant & {N{w_load_en && rst_n}};
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_last      <= SEL_W'(N - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data[w_grant_idx*W +: W];
            r_out_ch    <= w_grant_idx;
            r_last      <= w_grant_idx;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module : tb_stream_mux_rr
// Scoreboard bench for stream_mux_rr with N=4, W=32.
// Rev    : 1.0
// ============================================================================
module tb_stream_mux_rr;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sb[$];

    stream_mux_rr_if #(.N(4), .W(32)) bus ();

    stream_mux_rr #(.W(32), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        bus.in_data[ch*32 +: 32] = val;
    endtask

    // Monitor: inputs only change just after posedge, so a handshake seen
    // at negedge is the one that completes at the following posedge.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_unexpected: got ch %0d data 0x%0h expected none",
                         bus.out_ch, bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_ch", 32'(bus.out_ch), 32'(e.ch));
                chk("mon_data", bus.out_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        bus.mode_rr   = 1'b0;
        bus.sel       = 2'd2;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 32'h10 + i);
        set_data(2, 32'h7);

        // Reset state with every channel requesting.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Fixed select of channel 2.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("fix2_in_ready", 32'(bus.in_ready), 32'b0100);
        push(2'd2, 32'h7);
        tick();
        chk("fix2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("fix2_out_ch", 32'(bus.out_ch), 32'd2);

        // Selected channel idle: no grant, output drains to empty.
        bus.sel      = 2'd1;
        bus.in_valid = 4'b1101;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Fixed transfer from channel 3 leaves last=3 for the round-robin run.
        set_data(2, 32'h12);
        bus.sel      = 2'd3;
        bus.in_valid = 4'b1000;
        #1;
        chk("fix3_in_ready", 32'(bus.in_ready), 32'b1000);
        push(2'd3, 32'h13);
        tick();

        // Round-robin with all channels requesting: 0,1,2,3,0 without bubbles.
        bus.mode_rr  = 1'b1;
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_in_ready", 32'(bus.in_ready), 32'(1 << (k % 4)));
            push(2'(k % 4), 32'h10 + 32'(k % 4));
            tick();
            chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
            chk("rr_out_ch", 32'(bus.out_ch), 32'(k % 4));
        end

        // Backpressure holds channel 0 word and the pointer.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_data", bus.out_data, 32'h10);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 32'h11);
        tick();
        chk("bp_release_out_ch", 32'(bus.out_ch), 32'd1);
        bus.in_valid = 4'b0000;
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        // Single requester on channel 3, including when it is the last winner.
        bus.in_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("single_in_ready", 32'(bus.in_ready), 32'b1000);
            push(2'd3, 32'h13);
            tick();
            chk("single_out_valid", 32'(bus.out_valid), 32'd1);
            chk("single_out_ch", 32'(bus.out_ch), 32'd3);
        end
        bus.in_valid = 4'b0000;
        tick();

        // Mid-stream asynchronous reset drops the held word.
        bus.in_valid = 4'b0001;
        push(2'd0, 32'h10);
        tick();
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 4'b1010;
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'b0010);
        push(2'd1, 32'h11);
        tick();
        chk("post_rst_out_ch", 32'(bus.out_ch), 32'd1);
        bus.in_valid = 4'b0000;
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
